decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL be parametrised as follows, one per line: name, default, meaning.
- XLEN, 32, datapath width for PC and immediate; legal values 32 and 64.
- SKID_EN, 1, 1 = two-entry skid buffer; 0 = single output register with combinational ready.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous flush of all held entries.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction.
- i_instr  in  32  instruction word.
- i_pc  in  XLEN  instruction PC.
- o_valid  out  1  decoded bundle valid.
- i_ready  in  1  downstream accepts the bundle.
- o_pc  out  XLEN  PC of the bundle.
- o_class  out  9  one-hot class: OP, OP_IMM, BRANCH, LUI, AUIPC, JAL, JALR, LOAD, STORE (bit 0..8).
- o_alu_op  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- o_funct3  out  3  raw funct3 (branch condition / load-store size).
- o_rs1, o_rs2, o_rd  out  5 each  register indices.
- o_rd_we  out  1  destination write enable.
- o_imm  out  XLEN  sign-extended immediate for the class.
- o_illegal  out  1  instruction not a legal RV32I base encoding.

Function
REQ-003 An instruction SHALL be accepted when i_valid && o_ready at a rising edge, and its bundle SHALL appear with o_valid=1 exactly one cycle later if the output register was empty or drained that cycle.
REQ-004 A bundle SHALL hold stable while o_valid && !i_ready and SHALL retire on o_valid && i_ready.
REQ-005 SKID_EN=1: o_ready SHALL be a register output equal to !skid_full; an accept while the output is stalled SHALL load the skid entry; when the output retires with the skid full, the skid entry SHALL move to the output the same edge.
REQ-006 SKID_EN=1 SHALL sustain one instruction per cycle with i_ready held high, and SHALL preserve program order under any backpressure pattern.
REQ-007 SKID_EN=0: o_ready SHALL equal !o_valid || i_ready.
REQ-008 i_flush SHALL clear both entries at the edge (o_valid=0, skid empty, o_ready=1 next cycle), SHALL take priority over a simultaneous accept, and the instruction presented that cycle SHALL be dropped.
REQ-009 alu_op SHALL be:
- OP/OP_IMM: from funct3; funct7[5] selects SUB (OP only) or SRA.
- LOAD/STORE/JAL/JALR/AUIPC/LUI: ADD.
- BRANCH: SUB for funct3 BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
REQ-010 The immediate SHALL be in I, S, B, U or J format by class, sign-extended from bit 31 to XLEN; OP SHALL produce imm=0.
REQ-011 o_rd_we SHALL be 1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR and LOAD with rd!=0, and 0 otherwise.
REQ-012 o_illegal SHALL be 1 for any of:
- unlisted opcode, or instr[1:0]!=11;
- OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
- OP_IMM shift with a bad funct7;
- BRANCH funct3 010/011;
- JALR funct3!=000;
- LOAD funct3 011/110/111;
- STORE funct3>=011.
REQ-013 An illegal bundle SHALL still flow through with o_class=0 and o_rd_we=0.

Reset
REQ-014 While i_rst_n=0, these outputs SHALL be 0: o_valid, o_class, o_alu_op, o_funct3, o_rs1, o_rs2, o_rd, o_rd_we, o_imm, o_pc, o_illegal. The skid entry SHALL be empty, and o_ready SHALL be 0.
REQ-015 Assertion of i_rst_n=0 SHALL take effect without a clock edge and SHALL discard in-flight entries. o_ready SHALL rise on the first edge after deassertion.

Verification
REQ-016 Bench SHALL cover:
- 0x00500093 (addi x1,x0,5) -> next cycle o_class=OP_IMM, alu_op=0, rd=1, rd_we=1, imm=5.
- 0x402081B3 (sub x3,x1,x2) -> alu_op=1, rs1=1, rs2=2, rd=3, imm=0.
- 0xFE000EE3 (beq x0,x0,-4) -> class BRANCH, alu_op=1, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC), rd_we=0.
- i_ready=0 for 3 cycles with 3 back-to-back valids -> 2 accepted, o_ready=0 on cycle 3, all 3 emerge in order after release.
- i_flush with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1, no stale bundle appears.
- 0x00000000 and 0x0000A003 (lw funct3=010 passes, funct3 011 variant 0x0000B003) -> o_illegal=1 for 0x00000000 and 0x0000B003 only; async reset mid-stall -> o_valid=0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: a combinational decoder feeds an output register, optionally
// backed by a skid entry so that upstream ready comes straight from a flop.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [8:0]      o_class,
    output logic [3:0]      o_alu_op,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam int C_OP     = 0;
    localparam int C_OP_IMM = 1;
    localparam int C_BRANCH = 2;
    localparam int C_LUI    = 3;
    localparam int C_AUIPC  = 4;
    localparam int C_JAL    = 5;
    localparam int C_JALR   = 6;
    localparam int C_LOAD   = 7;
    localparam int C_STORE  = 8;

    // Every class that writes rd: all except BRANCH and STORE.
    localparam logic [8:0] RD_WE_MASK = 9'b0_1111_1011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [8:0]      cls;
        logic [3:0]      alu_op;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    logic [8:0]        cls;
    logic              illegal;
    alu_op_e           alu_op;
    bundle_t           dec;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        opcode  = i_instr[6:0];
        funct3  = i_instr[14:12];
        funct7  = i_instr[31:25];
        imm_i   = {{20{i_instr[31]}}, i_instr[31:20]};
        imm_s   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        imm_b   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        imm_u   = {i_instr[31:12], 12'b0};
        imm_j   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        cls     = '0;
        alu_op  = ALU_ADD;
        imm_sel = '0;
        illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                cls[C_OP] = 1'b1;
                alu_op    = alu_from_funct3(funct3, funct7[5]);
                illegal   = !((funct7 == 7'b0000000) ||
                              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                cls[C_OP_IMM] = 1'b1;
                alu_op        = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                imm_sel       = imm_i;
                illegal       = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                                (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
            end
            OPC_BRANCH: begin
                cls[C_BRANCH] = 1'b1;
                imm_sel       = imm_b;
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
                illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                cls[C_LUI] = 1'b1;
                imm_sel    = imm_u;
            end
            OPC_AUIPC: begin
                cls[C_AUIPC] = 1'b1;
                imm_sel      = imm_u;
            end
            OPC_JAL: begin
                cls[C_JAL] = 1'b1;
                imm_sel    = imm_j;
            end
            OPC_JALR: begin
                cls[C_JALR] = 1'b1;
                imm_sel     = imm_i;
                illegal     = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                cls[C_LOAD] = 1'b1;
                imm_sel     = imm_i;
                illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                cls[C_STORE] = 1'b1;
                imm_sel      = imm_s;
                illegal      = (funct3 >= 3'b011);
            end
            default: illegal = 1'b1;
        endcase

        dec         = '0;
        dec.pc      = i_pc;
        dec.cls     = illegal ? 9'b0 : cls;
        dec.alu_op  = alu_op;
        dec.funct3  = funct3;
        dec.rs1     = i_instr[19:15];
        dec.rs2     = i_instr[24:20];
        dec.rd      = i_instr[11:7];
        dec.rd_we   = !illegal && (i_instr[11:7] != 5'd0) && |(cls & RD_WE_MASK);
        dec.imm     = XLEN'(imm_sel);
        dec.illegal = illegal;
    end

    bundle_t out_q, out_n, skid_q, skid_n;
    logic    out_valid_q, out_valid_n, skid_valid_q, skid_valid_n;
    logic    ready_q, ready_n;
    logic    accept, out_free;

    // ready_q doubles as "out of reset": it holds o_ready low until the first edge.
    assign out_free = !out_valid_q || i_ready;
    assign o_ready  = SKID_EN ? ready_q : (ready_q && out_free);
    assign accept   = i_valid && o_ready;

    always_comb begin
        out_n        = out_q;
        out_valid_n  = out_valid_q;
        skid_n       = skid_q;
        skid_valid_n = skid_valid_q;
        if (i_flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_n        = skid_q;
                out_valid_n  = 1'b1;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                out_n       = dec;
                out_valid_n = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_n       = dec;
            skid_valid_n = 1'b1;
        end
        ready_n = SKID_EN ? !skid_valid_n : 1'b1;
    end

    // NOTE: payload registers are reset too, because the outputs must read zero during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            out_q        <= out_n;
            skid_q       <= skid_n;
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            ready_q      <= ready_n;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_pc      = out_q.pc;
    assign o_class   = out_q.cls;
    assign o_alu_op  = out_q.alu_op;
    assign o_funct3  = out_q.funct3;
    assign o_rs1     = out_q.rs1;
    assign o_rs2     = out_q.rs2;
    assign o_rd      = out_q.rd;
    assign o_rd_we   = out_q.rd_we;
    assign o_imm     = out_q.imm;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded expected bundles go into a
// scoreboard on accept and are compared when the stage retires a bundle.
`timescale 1ns/1ps
module tb_decode_stage;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [8:0]      cls;
        logic [3:0]      alu;
        logic [2:0]      f3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] imm;
        logic            ill;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            i_flush, i_valid, i_ready;
    logic            o_ready, o_valid;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] o_pc, o_imm;
    logic [8:0]      o_class;
    logic [3:0]      o_alu_op;
    logic [2:0]      o_funct3;
    logic [4:0]      o_rs1, o_rs2, o_rd;
    logic            o_rd_we, o_illegal;

    int   checks   = 0;
    int   failures = 0;
    int   retired  = 0;
    int   base;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t got;
    logic accepted;

    logic [31:0] prog [10];
    exp_t        pexp [10];

    decode_stage #(.XLEN(XLEN), .SKID_EN(1'b1)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_instr  (i_instr),
        .i_pc     (i_pc),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_pc     (o_pc),
        .o_class  (o_class),
        .o_alu_op (o_alu_op),
        .o_funct3 (o_funct3),
        .o_rs1    (o_rs1),
        .o_rs2    (o_rs2),
        .o_rd     (o_rd),
        .o_rd_we  (o_rd_we),
        .o_imm    (o_imm),
        .o_illegal(o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [XLEN-1:0] pc, input logic [8:0] cls,
                                input logic [3:0] alu, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we,
                                input logic [XLEN-1:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.cls = cls; e.alu = alu; e.f3 = f3;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we;
        e.imm = imm; e.ill = ill;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic present(input logic [31:0] instr, input exp_t e);
        i_instr = instr;
        i_pc    = e.pc;
        i_valid = 1'b1;
        cur_exp = e;
    endtask

    // Sample handshakes on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        accepted = i_valid && o_ready;
        if (o_valid && i_ready) begin
            check("retire_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("bundle", {o_pc, o_class, o_alu_op, o_funct3, o_rs1, o_rs2,
                                 o_rd, o_rd_we, o_imm, o_illegal}, got);
                retired++;
            end
        end
        if (i_flush) sb.delete();
        else if (accepted) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 32'h402081B3; pexp[0] = mk(32'h104, 9'h001, 4'd1, 3'd0, 5'd1, 5'd2, 5'd3,  1'b1, 32'h0, 1'b0);
        prog[1] = 32'hFE000EE3; pexp[1] = mk(32'h108, 9'h004, 4'd1, 3'd0, 5'd0, 5'd0, 5'd29, 1'b0, 32'hFFFFFFFC, 1'b0);
        prog[2] = 32'h00000000; pexp[2] = mk(32'h10C, 9'h000, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0,  1'b0, 32'h0, 1'b1);
        prog[3] = 32'h0000A003; pexp[3] = mk(32'h110, 9'h080, 4'd0, 3'd2, 5'd1, 5'd0, 5'd0,  1'b0, 32'h0, 1'b0);
        prog[4] = 32'h0000B003; pexp[4] = mk(32'h114, 9'h000, 4'd0, 3'd3, 5'd1, 5'd0, 5'd0,  1'b0, 32'h0, 1'b1);
        prog[5] = 32'h000010E7; pexp[5] = mk(32'h118, 9'h000, 4'd0, 3'd1, 5'd0, 5'd0, 5'd1,  1'b0, 32'h0, 1'b1);
        prog[6] = 32'h40109093; pexp[6] = mk(32'h11C, 9'h000, 4'd2, 3'd1, 5'd1, 5'd1, 5'd1,  1'b0, 32'h401, 1'b1);
        prog[7] = 32'h0020C863; pexp[7] = mk(32'h120, 9'h004, 4'd3, 3'd4, 5'd1, 5'd2, 5'd16, 1'b0, 32'h10, 1'b0);
        prog[8] = 32'h00001017; pexp[8] = mk(32'h124, 9'h010, 4'd0, 3'd1, 5'd0, 5'd0, 5'd0,  1'b0, 32'h1000, 1'b0);
        prog[9] = 32'h008000EF; pexp[9] = mk(32'h128, 9'h020, 4'd0, 3'd0, 5'd0, 5'd8, 5'd1,  1'b1, 32'h8, 1'b0);

        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_instr = '0; i_pc = '0;

        // Reset state, then o_ready rises on the first edge after release.
        #12;
        check("reset_outputs", {o_valid, o_pc, o_class, o_alu_op, o_funct3, o_rs1, o_rs2,
                                o_rd, o_rd_we, o_imm, o_illegal}, 0);
        check("reset_ready", o_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("ready_before_edge", o_ready, 0);
        tick();
        check("ready_after_edge", o_ready, 1);

        // addi: one-cycle latency, then a back-to-back stream at full rate.
        present(32'h00500093, mk(32'h100, 9'h002, 4'd0, 3'd0, 5'd0, 5'd5, 5'd1, 1'b1, 32'h5, 1'b0));
        tick();
        check("addi_accept", accepted, 1);
        check("addi_latency_valid", o_valid, 1);
        check("addi_class", o_class, 9'h002);
        for (int k = 0; k < 10; k++) begin
            present(prog[k], pexp[k]);
            tick();
            check("stream_accept", accepted, 1);
        end
        drain();

        // Three valids against a stalled output: two accepted, third waits.
        base = retired;
        i_ready = 1'b0;
        present(32'h407352B3, mk(32'h200, 9'h001, 4'd7, 3'd5, 5'd6, 5'd7, 5'd5, 1'b1, 32'h0, 1'b0));
        tick();
        check("stall_acc1", accepted, 1);
        present(32'hFE20AC23, mk(32'h204, 9'h100, 4'd0, 3'd2, 5'd1, 5'd2, 5'd24, 1'b0, 32'hFFFFFFF8, 1'b0));
        tick();
        check("stall_acc2", accepted, 1);
        present(32'h12345537, mk(32'h208, 9'h008, 4'd0, 3'd5, 5'd8, 5'd3, 5'd10, 1'b1, 32'h12345000, 1'b0));
        check("stall_ready_low", o_ready, 0);
        tick();
        check("stall_acc3", accepted, 0);
        check("stall_hold_pc", o_pc, 32'h200);
        i_ready = 1'b1;
        tick();
        check("release_no_accept", accepted, 0);
        tick();
        check("release_accept_c", accepted, 1);
        drain();
        check("stall_retired", retired - base, 3);

        // Flush with both entries full and a new instruction presented.
        i_ready = 1'b0;
        present(32'h008000EF, mk(32'h300, 9'h020, 4'd0, 3'd0, 5'd0, 5'd8, 5'd1, 1'b1, 32'h8, 1'b0));
        tick();
        present(32'h0020C863, mk(32'h304, 9'h004, 4'd3, 3'd4, 5'd1, 5'd2, 5'd16, 1'b0, 32'h10, 1'b0));
        tick();
        check("flush_prefull", o_ready, 0);
        present(32'h00001017, mk(32'h308, 9'h010, 4'd0, 3'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1000, 1'b0));
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_valid", o_valid, 0);
        check("flush_ready", o_ready, 1);
        i_ready = 1'b1;
        base = retired;
        for (int n = 0; n < 3; n++) tick();
        check("flush_no_stale", retired - base, 0);
        present(32'h00001017, mk(32'h30C, 9'h010, 4'd0, 3'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1000, 1'b0));
        tick();
        check("post_flush_accept", accepted, 1);
        drain();

        // Asynchronous reset while stalled with both entries held.
        i_ready = 1'b0;
        present(32'h00500093, mk(32'h400, 9'h002, 4'd0, 3'd0, 5'd0, 5'd5, 5'd1, 1'b1, 32'h5, 1'b0));
        tick();
        present(32'h402081B3, mk(32'h404, 9'h001, 4'd1, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 1'b0));
        tick();
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_ready", o_ready, 0);
        check("async_rst_outputs", {o_pc, o_class, o_alu_op, o_funct3, o_rs1, o_rs2,
                                    o_rd, o_rd_we, o_imm, o_illegal}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rerst_ready_before_edge", o_ready, 0);
        tick();
        check("rerst_ready_after_edge", o_ready, 1);
        i_ready = 1'b1;
        base = retired;
        tick();
        tick();
        check("rerst_no_stale", retired - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
